// File: rtl/lcd_frame_sched.sv
// Frame scheduler: window-set commands then RGB565 pixels as byte pairs to the SPI transmitter.
// Optional abort input enabled by defining LCD_SCHED_ABORT_EN.
module lcd_frame_sched #(
  parameter int H_RES      = 240,
  parameter int V_RES      = 135,
  parameter int X_OFS      = 40,
  parameter int Y_OFS      = 53,
  parameter int GAP_CYCLES = 1000
) (
  input  logic        oscclk,
  input  logic        reset,
  input  logic        start,
  input  logic        frame_en,
`ifdef LCD_SCHED_ABORT_EN
  input  logic        abort,
`endif
  input  logic [15:0] pixel,
  output logic [15:0] pixel_cnt,
  output logic [7:0]  tx_data,
  output logic        tx_dc,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [15:0] XO   = 16'(X_OFS);
  localparam logic [15:0] YO   = 16'(Y_OFS);
  localparam logic [15:0] XE   = 16'(X_OFS + H_RES - 1);
  localparam logic [15:0] YE   = 16'(Y_OFS + V_RES - 1);
  localparam logic [15:0] LAST = 16'(H_RES * V_RES - 1);
  localparam int          GW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_MAX = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    PIX_HI,
    PIX_LO,
    GAP
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    byte_cnt_q, byte_cnt_d;
  logic [15:0]   pix_cnt_q, pix_cnt_d;
  logic [7:0]    lo_q, lo_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic          abort_q, abort_d;
  logic          acc;
  logic [7:0]    cmd_byte;
  logic          cmd_dc;

  assign tx_valid  = (state_q == CMD) || (state_q == PIX_HI)
                  || (state_q == PIX_LO);
  assign busy      = (state_q != IDLE);
  assign pixel_cnt = pix_cnt_q;
  assign acc       = tx_valid && tx_ready;

  always_comb begin
    cmd_byte = 8'h00;
    cmd_dc   = 1'b1;
    unique case (byte_cnt_q)
      4'd0:    begin cmd_byte = 8'h2A; cmd_dc = 1'b0; end
      4'd1:    cmd_byte = XO[15:8];
      4'd2:    cmd_byte = XO[7:0];
      4'd3:    cmd_byte = XE[15:8];
      4'd4:    cmd_byte = XE[7:0];
      4'd5:    begin cmd_byte = 8'h2B; cmd_dc = 1'b0; end
      4'd6:    cmd_byte = YO[15:8];
      4'd7:    cmd_byte = YO[7:0];
      4'd8:    cmd_byte = YE[15:8];
      4'd9:    cmd_byte = YE[7:0];
      default: begin cmd_byte = 8'h2C; cmd_dc = 1'b0; end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    lo_d       = lo_q;
    gap_cnt_d  = gap_cnt_q;
    abort_d    = abort_q;
    tx_data    = 8'h00;
    tx_dc      = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          state_d    = CMD;
          byte_cnt_d = 4'd0;
        end
      end
      CMD: begin
        tx_data = cmd_byte;
        tx_dc   = cmd_dc;
        if (acc) begin
          if (byte_cnt_q == 4'd10) begin
            state_d    = PIX_HI;
            byte_cnt_d = 4'd0;
          end else begin
            byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end
      end
      PIX_HI: begin
        tx_data = pixel[15:8];
        tx_dc   = 1'b1;
        if (acc) begin
          lo_d    = pixel[7:0];
          state_d = PIX_LO;
        end
      end
      PIX_LO: begin
        tx_data = lo_q;
        tx_dc   = 1'b1;
        if (acc) begin
          if (pix_cnt_q == LAST) begin
            frame_done = 1'b1;
            pix_cnt_d  = 16'd0;
            gap_cnt_d  = '0;
            state_d    = GAP;
          end else begin
            pix_cnt_d = pix_cnt_q + 16'd1;
            state_d   = PIX_HI;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_MAX) begin
          gap_cnt_d  = '0;
          byte_cnt_d = 4'd0;
          state_d    = frame_en ? CMD : IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef LCD_SCHED_ABORT_EN
    // Abort is remembered until the in-flight byte is accepted.
    if (state_q == IDLE || state_q == GAP) begin
      if (abort) begin
        state_d    = IDLE;
        gap_cnt_d  = '0;
        byte_cnt_d = 4'd0;
        abort_d    = 1'b0;
      end
    end else if (acc && (abort || abort_q)) begin
      state_d    = IDLE;
      pix_cnt_d  = 16'd0;
      byte_cnt_d = 4'd0;
      frame_done = 1'b0;
      abort_d    = 1'b0;
    end else if (abort) begin
      abort_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge oscclk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      byte_cnt_q <= 4'd0;
      pix_cnt_q  <= 16'd0;
      lo_q       <= 8'h00;
      gap_cnt_q  <= '0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      lo_q       <= lo_d;
      gap_cnt_q  <= gap_cnt_d;
      abort_q    <= abort_d;
    end
  end

endmodule

// File: tb/tb_lcd_frame_sched.sv
// Self-checking bench for lcd_frame_sched with a queue-based byte stream model.
// Abort scenario is built when LCD_SCHED_ABORT_EN is defined.
module tb_lcd_frame_sched;
  localparam int H   = 4;
  localparam int V   = 2;
  localparam int XO  = 40;
  localparam int YO  = 53;
  localparam int GAP = 3;
  localparam int NB  = 11 + 2 * H * V;

  logic        oscclk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        frame_en = 1'b0;
  logic        tx_ready = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] pixel;
  logic [15:0] pixel_cnt;
  logic [7:0]  tx_data;
  logic        tx_dc;
  logic        tx_valid;
  logic        busy;
  logic        frame_done;
  logic [15:0] pix_base = 16'hF800;
  logic [15:0] pix_mul = 16'd1;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_d[$];
  logic       exp_c[$];
  logic [7:0] got_d[$];
  logic       got_c[$];
  int         done_at[$];
  int         hold_viol;
  int         busy_low;
  int         acc_total;

  assign pixel = pix_base + pixel_cnt * pix_mul;

  always #5 oscclk = ~oscclk;

  lcd_frame_sched #(
    .H_RES(H), .V_RES(V), .X_OFS(XO), .Y_OFS(YO), .GAP_CYCLES(GAP)
  ) dut (
    .oscclk(oscclk),
    .reset(reset),
    .start(start),
    .frame_en(frame_en),
`ifdef LCD_SCHED_ABORT_EN
    .abort(abort),
`endif
    .pixel(pixel),
    .pixel_cnt(pixel_cnt),
    .tx_data(tx_data),
    .tx_dc(tx_dc),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy(busy),
    .frame_done(frame_done)
  );

  task automatic build_exp();
    logic [15:0] xo, yo, xe, ye, v;
    xo = 16'(XO);
    yo = 16'(YO);
    xe = 16'(XO + H - 1);
    ye = 16'(YO + V - 1);
    exp_d.delete();
    exp_c.delete();
    exp_d.push_back(8'h2A);  exp_c.push_back(1'b0);
    exp_d.push_back(xo[15:8]); exp_c.push_back(1'b1);
    exp_d.push_back(xo[7:0]);  exp_c.push_back(1'b1);
    exp_d.push_back(xe[15:8]); exp_c.push_back(1'b1);
    exp_d.push_back(xe[7:0]);  exp_c.push_back(1'b1);
    exp_d.push_back(8'h2B);  exp_c.push_back(1'b0);
    exp_d.push_back(yo[15:8]); exp_c.push_back(1'b1);
    exp_d.push_back(yo[7:0]);  exp_c.push_back(1'b1);
    exp_d.push_back(ye[15:8]); exp_c.push_back(1'b1);
    exp_d.push_back(ye[7:0]);  exp_c.push_back(1'b1);
    exp_d.push_back(8'h2C);  exp_c.push_back(1'b0);
    for (int p = 0; p < H * V; p++) begin
      v = pix_base + 16'(p) * pix_mul;
      exp_d.push_back(v[15:8]); exp_c.push_back(1'b1);
      exp_d.push_back(v[7:0]);  exp_c.push_back(1'b1);
    end
  endtask

  task automatic clr();
    got_d.delete();
    got_c.delete();
    done_at.delete();
    hold_viol = 0;
    busy_low = 0;
    acc_total = 0;
  endtask

  task automatic do_start();
    @(negedge oscclk);
    tx_ready = 1'b0;
    start = 1'b1;
    @(posedge oscclk);
    #1;
    start = 1'b0;
  endtask

  task automatic collect(input int n, input int pct, output bit to);
    logic [7:0] pd;
    logic       pc;
    bit         pend;
    int         k;
    int         cyc;
    pend = 0; k = 0; cyc = 0; to = 0; pd = 8'h00; pc = 1'b0;
    while (k < n) begin
      @(negedge oscclk);
      tx_ready = ($urandom_range(99) < pct);
      #1;
      if (pend && (!tx_valid || tx_data !== pd || tx_dc !== pc))
        hold_viol++;
      if (!busy) busy_low++;
      if (tx_valid && tx_ready) begin
        got_d.push_back(tx_data);
        got_c.push_back(tx_dc);
        if (frame_done) done_at.push_back(acc_total);
        acc_total++;
        k++;
        pend = 0;
      end else begin
        if (frame_done) done_at.push_back(-1);
        pend = tx_valid;
        pd = tx_data;
        pc = tx_dc;
      end
      cyc++;
      if (cyc > 5000) begin
        to = 1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit to);
    to = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge oscclk);
      #1;
      if (!busy) begin
        to = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #3;
    checks++;
    if ({pixel_cnt, tx_data, tx_dc, tx_valid, busy, frame_done} !== 28'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0",
               {pixel_cnt, tx_data, tx_dc, tx_valid, busy, frame_done});
    end
    @(negedge oscclk);
    reset = 1'b1;
    @(negedge oscclk);
    #1;
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b valid=%b required 0 0", busy, tx_valid);
    end
  endtask

  task automatic test_frame();
    bit to;
    pix_base = 16'hF800;
    pix_mul = 16'd1;
    frame_en = 1'b0;
    build_exp();
    clr();
    do_start();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h2A || tx_dc !== 1'b0) begin
      errors++;
      $display("FAIL start_latency: valid=%b data=%h dc=%b required 1 2a 0",
               tx_valid, tx_data, tx_dc);
    end
    collect(NB, 100, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL frame_timeout: got %0d bytes required %0d", got_d.size(), NB);
    end
    for (int i = 0; i < got_d.size(); i++) begin
      checks++;
      if (got_d[i] !== exp_d[i] || got_c[i] !== exp_c[i]) begin
        errors++;
        $display("FAIL frame_byte[%0d]: got %h/%b required %h/%b",
                 i, got_d[i], got_c[i], exp_d[i], exp_c[i]);
      end
    end
    checks++;
    if (done_at.size() != 1 || done_at[0] != NB - 1) begin
      errors++;
      $display("FAIL frame_done_align: got %0d pulses first %0d required 1 at %0d",
               done_at.size(), (done_at.size() > 0) ? done_at[0] : -2, NB - 1);
    end
    checks++;
    if (busy_low != 0) begin
      errors++;
      $display("FAIL busy_in_frame: got %0d idle cycles required 0", busy_low);
    end
    for (int g = 0; g < GAP; g++) begin
      @(negedge oscclk);
      #1;
      checks++;
      if (tx_valid !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL gap_cycle[%0d]: valid=%b busy=%b required 0 1", g, tx_valid, busy);
      end
    end
    @(negedge oscclk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_gap: busy=%b required 0", busy);
    end
  endtask

  task automatic test_random_ready();
    bit to;
    int bad;
    frame_en = 1'b0;
    for (int r = 0; r < 3; r++) begin
      pix_base = 16'($urandom);
      pix_mul = 16'($urandom);
      build_exp();
      clr();
      do_start();
      collect(NB, 30, to);
      bad = 0;
      for (int i = 0; i < got_d.size(); i++)
        if (got_d[i] !== exp_d[i] || got_c[i] !== exp_c[i]) bad++;
      checks++;
      if (to || bad != 0 || got_d.size() != NB) begin
        errors++;
        $display("FAIL rand_stream[%0d]: got %0d bytes %0d wrong required %0d bytes 0 wrong",
                 r, got_d.size(), bad, NB);
      end
      checks++;
      if (hold_viol != 0) begin
        errors++;
        $display("FAIL rand_hold[%0d]: got %0d changes while stalled required 0", r, hold_viol);
      end
      checks++;
      if (done_at.size() != 1 || done_at[0] != NB - 1) begin
        errors++;
        $display("FAIL rand_done[%0d]: got %0d pulses required 1 at byte %0d",
                 r, done_at.size(), NB - 1);
      end
      wait_idle(to);
      checks++;
      if (to) begin
        errors++;
        $display("FAIL rand_idle[%0d]: busy stuck, required 0", r);
      end
    end
  endtask

  task automatic test_auto_restart();
    bit to;
    int n;
    int bad;
    int dones;
    pix_base = 16'($urandom);
    pix_mul = 16'd3;
    build_exp();
    clr();
    frame_en = 1'b1;
    do_start();
    collect(NB, 100, to);
    dones = done_at.size();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge oscclk);
      tx_ready = 1'b0;
      #1;
      if (tx_valid) break;
      n++;
    end
    checks++;
    if (n != GAP || tx_data !== 8'h2A || tx_dc !== 1'b0) begin
      errors++;
      $display("FAIL restart_gap: got %0d idle cycles then %h/%b required %0d then 2a/0",
               n, tx_data, tx_dc, GAP);
    end
    frame_en = 1'b0;
    clr();
    collect(NB, 100, to);
    bad = 0;
    for (int i = 0; i < got_d.size(); i++)
      if (got_d[i] !== exp_d[i] || got_c[i] !== exp_c[i]) bad++;
    checks++;
    if (to || bad != 0 || got_d.size() != NB) begin
      errors++;
      $display("FAIL restart_stream: got %0d bytes %0d wrong required %0d bytes 0 wrong",
               got_d.size(), bad, NB);
    end
    dones += done_at.size();
    checks++;
    if (dones != 2) begin
      errors++;
      $display("FAIL restart_done_count: got %0d required 2", dones);
    end
    wait_idle(to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL restart_idle: busy stuck, required 0");
    end
  endtask

  task automatic test_reset_midframe();
    bit to;
    int bad;
    pix_base = 16'h1234;
    pix_mul = 16'h0101;
    frame_en = 1'b0;
    build_exp();
    clr();
    do_start();
    collect(15, 100, to);
    @(negedge oscclk);
    tx_ready = 1'b0;
    start = 1'b1;
    @(negedge oscclk);
    start = 1'b0;
    collect(7, 100, to);
    bad = 0;
    for (int i = 0; i < got_d.size(); i++)
      if (got_d[i] !== exp_d[i] || got_c[i] !== exp_c[i]) bad++;
    checks++;
    if (to || bad != 0 || got_d.size() != 22) begin
      errors++;
      $display("FAIL start_ignored: got %0d bytes %0d wrong required 22 bytes 0 wrong",
               got_d.size(), bad);
    end
    @(posedge oscclk);
    #1;
    checks++;
    if (pixel_cnt !== 16'd5 || tx_data !== exp_d[22]) begin
      errors++;
      $display("FAIL pre_reset_pix: cnt=%0d data=%h required 5 %h", pixel_cnt, tx_data, exp_d[22]);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({pixel_cnt, tx_data, tx_dc, tx_valid, busy, frame_done} !== 28'd0) begin
      errors++;
      $display("FAIL async_reset: got %h required 0",
               {pixel_cnt, tx_data, tx_dc, tx_valid, busy, frame_done});
    end
    @(negedge oscclk);
    reset = 1'b1;
    clr();
    do_start();
    collect(NB, 100, to);
    bad = 0;
    for (int i = 0; i < got_d.size(); i++)
      if (got_d[i] !== exp_d[i] || got_c[i] !== exp_c[i]) bad++;
    checks++;
    if (to || bad != 0 || got_d.size() != NB) begin
      errors++;
      $display("FAIL post_reset_frame: got %0d bytes %0d wrong required %0d bytes 0 wrong",
               got_d.size(), bad, NB);
    end
    wait_idle(to);
  endtask

`ifdef LCD_SCHED_ABORT_EN
  task automatic test_abort();
    bit to;
    pix_base = 16'hA5C3;
    pix_mul = 16'd7;
    build_exp();
    clr();
    do_start();
    collect(17, 100, to);
    @(negedge oscclk);
    abort = 1'b1;
    tx_ready = 1'b0;
    #1;
    checks++;
    if (pixel_cnt !== 16'd3) begin
      errors++;
      $display("FAIL abort_pre_cnt: got %0d required 3", pixel_cnt);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge oscclk);
      tx_ready = 1'b0;
      #1;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== exp_d[17]) begin
        errors++;
        $display("FAIL abort_hold[%0d]: valid=%b data=%h required 1 %h",
                 i, tx_valid, tx_data, exp_d[17]);
      end
    end
    @(negedge oscclk);
    tx_ready = 1'b1;
    #1;
    checks++;
    if (tx_valid !== 1'b1 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_accept: valid=%b done=%b required 1 0", tx_valid, frame_done);
    end
    @(negedge oscclk);
    abort = 1'b0;
    tx_ready = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0 || pixel_cnt !== 16'd0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b valid=%b cnt=%0d required 0 0 0",
               busy, tx_valid, pixel_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_random_ready();
    test_auto_restart();
    test_reset_midframe();
`ifdef LCD_SCHED_ABORT_EN
    test_abort();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
